// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute T-state sequencer decoding IR opcodes into bus strobes
module control_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [7:0] instr,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic       pc_enable,
  output logic       pc_inc,
  output logic       pc_latch,
  output logic       mar_latch,
  output logic       ram_enable,
  output logic       ram_latch,
  output logic       ir_enable,
  output logic       ir_latch,
  output logic       a_enable,
  output logic       a_latch,
  output logic       b_latch,
  output logic       alu_enable,
  output logic       alu_sub,
  output logic       flags_latch,
  output logic       out_latch,
  output logic       halted,
  output logic [2:0] tstate
);
  typedef enum logic [2:0] {T0, T1, T2, T3, T4} tstate_e;
  typedef struct packed {
    logic pc_enable, pc_inc, pc_latch, mar_latch, ram_enable, ram_latch, ir_enable, ir_latch;
    logic a_enable, a_latch, b_latch, alu_enable, alu_sub, flags_latch, out_latch;
  } strobes_t;
  tstate_e state_q, state_d;
  strobes_t s;
  logic halted_q, halted_d, active, last;
  logic [3:0] op;
  assign op = instr[7:4];
  assign active = rst_n & run & ~halted_q;
  assign tstate = state_q;
  assign halted = halted_q;
  assign {pc_enable, pc_inc, pc_latch, mar_latch, ram_enable, ram_latch, ir_enable, ir_latch,
          a_enable, a_latch, b_latch, alu_enable, alu_sub, flags_latch, out_latch} = active ? s : '0;
  // T-state and halt registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= T0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end
  // raw strobe decode per step, end-of-instruction detect and next T-state
  always_comb begin
    s = '0;
    last = 1'b0;
    case (state_q)
      T0: begin s.pc_enable = 1'b1; s.mar_latch = 1'b1; end
      T1: begin s.ram_enable = 1'b1; s.ir_latch = 1'b1; s.pc_inc = 1'b1; end
      T2: case (op)
        4'h1, 4'h2, 4'h3, 4'h4: begin s.ir_enable = 1'b1; s.mar_latch = 1'b1; end
        4'h5: begin s.ir_enable = 1'b1; s.a_latch = 1'b1; last = 1'b1; end
        4'h6: begin s.ir_enable = 1'b1; s.pc_latch = 1'b1; last = 1'b1; end
        4'h7: begin s.ir_enable = carry_flag; s.pc_latch = carry_flag; last = 1'b1; end
        4'h8: begin s.ir_enable = zero_flag; s.pc_latch = zero_flag; last = 1'b1; end
        4'hE: begin s.a_enable = 1'b1; s.out_latch = 1'b1; last = 1'b1; end
        default: last = 1'b1;
      endcase
      T3: case (op)
        4'h1: begin s.ram_enable = 1'b1; s.a_latch = 1'b1; last = 1'b1; end
        4'h2, 4'h3: begin s.ram_enable = 1'b1; s.b_latch = 1'b1; end
        4'h4: begin s.a_enable = 1'b1; s.ram_latch = 1'b1; last = 1'b1; end
        default: last = 1'b1;
      endcase
      T4: begin
        last = 1'b1;
        if (op == 4'h2 || op == 4'h3) begin
          s.alu_enable = 1'b1;
          s.a_latch = 1'b1;
          s.flags_latch = 1'b1;
          s.alu_sub = (op == 4'h3);
        end
      end
      default: last = 1'b1;
    endcase
    state_d = halted_q ? T0 : state_q;
    halted_d = halted_q;
    if (active) begin
      state_d = last ? T0 : tstate_e'(state_q + 3'd1);
      halted_d = (state_q == T2) && (op == 4'hF);
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: vector table, corner sequences and random model-checked run
module tb_control_sequencer;
  logic clk = 1'b0, rst_n, run, carry_flag, zero_flag;
  logic [7:0] instr;
  logic pc_enable, pc_inc, pc_latch, mar_latch, ram_enable, ram_latch, ir_enable, ir_latch;
  logic a_enable, a_latch, b_latch, alu_enable, alu_sub, flags_latch, out_latch, halted;
  logic [2:0] tstate;
  localparam logic [14:0] PE = 15'h4000, PI = 15'h2000, PL = 15'h1000, ML = 15'h0800,
                          RE = 15'h0400, RL = 15'h0200, IE = 15'h0100, IL = 15'h0080,
                          AE = 15'h0040, AL = 15'h0020, BL = 15'h0010, XE = 15'h0008,
                          AS = 15'h0004, FL = 15'h0002, OL = 15'h0001;
  typedef struct {logic [14:0] s; logic [2:0] t; logic h;} exp_t;
  typedef struct {logic r, ru; logic [7:0] i; logic c, z; logic [14:0] s; logic [2:0] t; logic h; string n;} vec_t;
  exp_t q[$];
  vec_t tbl[$];
  int errors = 0, checks = 0, mt = 0;
  logic mh = 1'b0, inv_on = 1'b0;
  wire [14:0] obs = {pc_enable, pc_inc, pc_latch, mar_latch, ram_enable, ram_latch, ir_enable, ir_latch,
                     a_enable, a_latch, b_latch, alu_enable, alu_sub, flags_latch, out_latch};

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .pc_enable(pc_enable), .pc_inc(pc_inc), .pc_latch(pc_latch), .mar_latch(mar_latch),
    .ram_enable(ram_enable), .ram_latch(ram_latch), .ir_enable(ir_enable), .ir_latch(ir_latch),
    .a_enable(a_enable), .a_latch(a_latch), .b_latch(b_latch), .alu_enable(alu_enable),
    .alu_sub(alu_sub), .flags_latch(flags_latch), .out_latch(out_latch), .halted(halted), .tstate(tstate)
  );

  always #5 clk = ~clk;

  // reference strobes for one step of an instruction
  function automatic logic [14:0] dec(int t, logic [3:0] op, logic c, logic z);
    case (t)
      0: return PE | ML;
      1: return RE | IL | PI;
      2: case (op)
        4'h1, 4'h2, 4'h3, 4'h4: return IE | ML;
        4'h5: return IE | AL;
        4'h6: return IE | PL;
        4'h7: return c ? IE | PL : 15'h0;
        4'h8: return z ? IE | PL : 15'h0;
        4'hE: return AE | OL;
        default: return 15'h0;
      endcase
      3: case (op)
        4'h1: return RE | AL;
        4'h2, 4'h3: return RE | BL;
        4'h4: return AE | RL;
        default: return 15'h0;
      endcase
      4: return op == 4'h2 ? XE | AL | FL : op == 4'h3 ? XE | AL | FL | AS : 15'h0;
      default: return 15'h0;
    endcase
  endfunction

  function automatic int len(logic [3:0] op);
    return (op == 4'h1 || op == 4'h4) ? 4 : (op == 4'h2 || op == 4'h3) ? 5 : 3;
  endfunction

  function automatic logic [14:0] model_s();
    return (rst_n && run && !mh) ? dec(mt, instr[7:4], carry_flag, zero_flag) : 15'h0;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin mt = 0; mh = 1'b0; end
    else if (mh) mt = 0;
    else if (run) begin
      if (mt == 2 && instr[7:4] == 4'hF) mh = 1'b1;
      mt = (mt + 1 >= len(instr[7:4])) ? 0 : mt + 1;
    end
  endtask

  task automatic drive(input logic r, ru, input logic [7:0] i, input logic c, z);
    rst_n = r; run = ru; instr = i; carry_flag = c; zero_flag = z;
  endtask

  task automatic cyc(input logic [14:0] s, input logic [2:0] t, input logic h, input string name);
    exp_t e;
    e.s = s; e.t = t; e.h = h;
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    checks++;
    if (obs !== e.s || tstate !== e.t || halted !== e.h) begin
      errors++;
      $display("FAIL %s: got strobes=%h tstate=%0d halted=%b, expected strobes=%h tstate=%0d halted=%b",
               name, obs, tstate, halted, e.s, e.t, e.h);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic mstep(input string name);
    cyc(model_s(), 3'(mt), mh, name);
  endtask

  task automatic add(input logic r, ru, input logic [7:0] i, input logic c, z,
                     input logic [14:0] s, input logic [2:0] t, input logic h, input string n);
    vec_t v;
    v.r = r; v.ru = ru; v.i = i; v.c = c; v.z = z; v.s = s; v.t = t; v.h = h; v.n = n;
    tbl.push_back(v);
  endtask

  // bus one-hot and tstate range during the random phase
  always @(negedge clk) begin
    if (inv_on) begin
      checks++;
      if ($countones({pc_enable, ram_enable, ir_enable, a_enable, alu_enable}) > 1 || tstate > 3'd4) begin
        errors++;
        $display("FAIL invariant: bus enables=%b tstate=%0d, expected at most one enable and tstate<=4",
                 {pc_enable, ram_enable, ir_enable, a_enable, alu_enable}, tstate);
      end
    end
  end

  initial begin
    drive(0, 1, 8'h1A, 0, 0);
    @(posedge clk);
    #1;
    add(0, 1, 8'h1A, 0, 0, 15'h0, 0, 0, "reset");
    add(1, 1, 8'h1A, 0, 0, PE | ML, 0, 0, "lda_t0");
    add(1, 1, 8'h1A, 0, 0, RE | IL | PI, 1, 0, "lda_t1");
    add(1, 1, 8'h1A, 0, 0, IE | ML, 2, 0, "lda_t2");
    add(1, 1, 8'h1A, 0, 0, RE | AL, 3, 0, "lda_t3");
    add(1, 1, 8'h33, 0, 0, PE | ML, 0, 0, "sub_t0");
    add(1, 1, 8'h33, 0, 0, RE | IL | PI, 1, 0, "sub_t1");
    add(1, 1, 8'h33, 0, 0, IE | ML, 2, 0, "sub_t2");
    add(1, 1, 8'h33, 0, 0, RE | BL, 3, 0, "sub_t3");
    add(1, 1, 8'h33, 0, 0, XE | AL | FL | AS, 4, 0, "sub_t4");
    add(1, 1, 8'h25, 0, 0, PE | ML, 0, 0, "add_t0");
    add(1, 1, 8'h25, 0, 0, RE | IL | PI, 1, 0, "add_t1");
    add(1, 1, 8'h25, 0, 0, IE | ML, 2, 0, "add_t2");
    for (int i = 0; i < 4; i++) add(1, 0, 8'h25, 0, 0, 15'h0, 3, 0, "add_paused");
    add(1, 1, 8'h25, 0, 0, RE | BL, 3, 0, "add_t3_resumed");
    add(1, 1, 8'h25, 0, 0, XE | AL | FL, 4, 0, "add_t4");
    add(1, 1, 8'h70, 0, 0, PE | ML, 0, 0, "jc0_t0");
    add(1, 1, 8'h70, 0, 0, RE | IL | PI, 1, 0, "jc0_t1");
    add(1, 1, 8'h70, 0, 0, 15'h0, 2, 0, "jc0_t2");
    add(1, 1, 8'h70, 1, 0, PE | ML, 0, 0, "jc1_t0");
    add(1, 1, 8'h70, 1, 0, RE | IL | PI, 1, 0, "jc1_t1");
    add(1, 1, 8'h70, 1, 0, IE | PL, 2, 0, "jc1_t2");
    add(1, 1, 8'hE0, 0, 0, PE | ML, 0, 0, "out_t0");
    add(1, 1, 8'hE0, 0, 0, RE | IL | PI, 1, 0, "out_t1");
    add(1, 1, 8'hE0, 0, 0, AE | OL, 2, 0, "out_t2");
    add(1, 1, 8'hF0, 0, 0, PE | ML, 0, 0, "hlt_t0");
    add(1, 1, 8'hF0, 0, 0, RE | IL | PI, 1, 0, "hlt_t1");
    add(1, 1, 8'hF0, 0, 0, 15'h0, 2, 0, "hlt_t2");
    foreach (tbl[k]) begin
      drive(tbl[k].r, tbl[k].ru, tbl[k].i, tbl[k].c, tbl[k].z);
      cyc(tbl[k].s, tbl[k].t, tbl[k].h, tbl[k].n);
    end
    drive(1, 1, 8'h25, 1, 1);
    for (int i = 0; i < 10; i++) cyc(15'h0, 0, 1, "halted_parked");
    drive(0, 1, 8'h25, 0, 0);
    cyc(15'h0, 0, 1, "halted_during_reset");
    drive(1, 1, 8'h80, 0, 0);
    cyc(PE | ML, 0, 0, "post_reset_t0");
    mstep("jz_t1");
    @(negedge clk);
    checks++;
    if (obs !== 15'h0 || tstate !== 3'd2) begin
      errors++;
      $display("FAIL jz_t2_z0: got strobes=%h tstate=%0d, expected strobes=0000 tstate=2", obs, tstate);
    end
    zero_flag = 1'b1;
    #1;
    checks++;
    if (obs !== (IE | PL)) begin
      errors++;
      $display("FAIL jz_t2_z1: got strobes=%h, expected strobes=%h", obs, IE | PL);
    end
    @(posedge clk);
    model_edge();
    #1;
    mstep("jz_next_t0");
    inv_on = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0, 8'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      mstep("random");
    end
    inv_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
